// File: rtl/song_sequencer_if.sv
// Control/status bundle between a song player and its controller.
// Signals: start/stop pulses in, music/note_idx/playing/done out.
interface song_sequencer_if;
  logic       start;
  logic       stop;
  logic [4:0] music;
  logic       playing;
  logic       done;
  logic [4:0] note_idx;

  modport master (
    output start, stop,
    input  music, playing, done, note_idx
  );

  modport slave (
    input  start, stop,
    output music, playing, done, note_idx
  );
endinterface

// File: rtl/song_sequencer.sv
// Plays a fixed tune from an internal 32x8 ROM {note,beats} with gaps.
// Ports: clk, rst_n (async low), bus (slave: start/stop in; music,
// playing, done, note_idx out). Option macro SONG_LOOP_EN: restart
// from entry 0 at end of song instead of returning to idle.
module song_sequencer #(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 500_000
) (
  input  logic               clk,
  input  logic               rst_n,
  song_sequencer_if.slave    bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NOTE = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  beat_q, beat_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  music_q, music_d;
  logic        done_q, done_d;
  logic [7:0]  nxt;
  logic [7:0]  first;

  function automatic logic [7:0] rom(input logic [4:0] a);
    logic [7:0] r;
    case (a)
      5'd0:    r = {5'd8,  3'd1};
      5'd1:    r = {5'd8,  3'd1};
      5'd2:    r = {5'd12, 3'd1};
      5'd3:    r = {5'd12, 3'd1};
      5'd4:    r = {5'd13, 3'd1};
      5'd5:    r = {5'd13, 3'd1};
      5'd6:    r = {5'd12, 3'd2};
      5'd7:    r = {5'd11, 3'd1};
      5'd8:    r = {5'd11, 3'd1};
      5'd9:    r = {5'd10, 3'd1};
      5'd10:   r = {5'd10, 3'd1};
      5'd11:   r = {5'd9,  3'd1};
      5'd12:   r = {5'd9,  3'd1};
      5'd13:   r = {5'd8,  3'd2};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    music_d = music_q;
    done_d  = 1'b0;
    nxt     = rom(idx_q + 5'd1);
    first   = rom(5'd0);
    if (bus.stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      beat_d  = '0;
      idx_d   = '0;
      music_d = '0;
    end else begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          if (bus.start) begin
            state_d = S_NOTE;
            cnt_d   = '0;
            idx_d   = '0;
            music_d = first[7:3];
            beat_d  = first[2:0];
          end
        end
        (state_q == S_NOTE): begin
          if (cnt_q == BEAT_LAST) begin
            cnt_d = '0;
            if (beat_q == 3'd1) begin
              state_d = S_GAP;
              music_d = '0;
            end else begin
              beat_d = beat_q - 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        (state_q == S_GAP): begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            if (idx_q == 5'd31 || nxt[2:0] == 3'd0) begin
              done_d = 1'b1;
`ifdef SONG_LOOP_EN
              state_d = S_NOTE;
              idx_d   = '0;
              music_d = first[7:3];
              beat_d  = first[2:0];
`else
              state_d = S_IDLE;
              idx_d   = '0;
              music_d = '0;
              beat_d  = '0;
`endif
            end else begin
              state_d = S_NOTE;
              idx_d   = idx_q + 5'd1;
              music_d = nxt[7:3];
              beat_d  = nxt[2:0];
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          beat_d  = '0;
          idx_d   = '0;
          music_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      music_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      music_q <= music_d;
      done_q  <= done_d;
    end
  end

  assign bus.music    = music_q;
  assign bus.note_idx = idx_q;
  assign bus.done     = done_q;
  assign bus.playing  = (state_q != S_IDLE);

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with BEAT_CYCLES=10, GAP_CYCLES=2.
// Checks reset, full song timing, stop, control conflicts, reset mid-gap.
module tb_song_sequencer;

  logic clk;
  logic rst_n;
  int   n_asserts;
  int   n_fail;

  song_sequencer_if bus ();

  song_sequencer #(
    .BEAT_CYCLES(10),
    .GAP_CYCLES (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tnote [14] = '{8, 8, 12, 12, 13, 13, 12, 11, 11, 10, 10, 9, 9, 8};
  int tbeat [14] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2};

  task automatic chk(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // cycle c (1-based after the sampling edge) -> expected music / entry
  function automatic void exp_at(input int c, output int m, output int ix);
    int t;
    t  = c;
    m  = 0;
    ix = 0;
    for (int e = 0; e < 14; e++) begin
      ix = e;
      if (t <= tbeat[e] * 10) begin
        m = tnote[e];
        return;
      end
      t -= tbeat[e] * 10;
      if (t <= 2) begin
        m = 0;
        return;
      end
      t -= 2;
    end
  endfunction

  task automatic check_cycle(input string tag, input int c);
    int m;
    int ix;
    exp_at(c, m, ix);
    chk({tag, "_music"}, int'(bus.music), m);
    chk({tag, "_idx"}, int'(bus.note_idx), ix);
    chk({tag, "_playing"}, int'(bus.playing), 1);
    chk({tag, "_done"}, int'(bus.done), 0);
  endtask

  task automatic pulse_start_and_step();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    chk("rst_music", int'(bus.music), 0);
    chk("rst_playing", int'(bus.playing), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_idx", int'(bus.note_idx), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_playing", int'(bus.playing), 0);

    // full song; a start pulse mid-song must be ignored
    pulse_start_and_step();
    for (int c = 1; c <= 188; c++) begin
      check_cycle("song", c);
      if (c == 50) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("end_done", int'(bus.done), 1);
`ifdef SONG_LOOP_EN
    chk("loop_playing", int'(bus.playing), 1);
    chk("loop_music", int'(bus.music), 8);
    chk("loop_idx", int'(bus.note_idx), 0);
    @(negedge clk);
    for (int c = 2; c <= 188; c++) begin
      check_cycle("pass2", c);
      @(negedge clk);
    end
    chk("loop2_done", int'(bus.done), 1);
    chk("loop2_music", int'(bus.music), 8);
    do_stop();
    chk("loop_stop_playing", int'(bus.playing), 0);
    chk("loop_stop_music", int'(bus.music), 0);
`else
    chk("end_playing", int'(bus.playing), 0);
    chk("end_music", int'(bus.music), 0);
    chk("end_idx", int'(bus.note_idx), 0);
    @(negedge clk);
    chk("end_done_clr", int'(bus.done), 0);
    chk("end_still_idle", int'(bus.playing), 0);
`endif

    // stop mid-note during entry 3 (cycles 37..46)
    @(negedge clk);
    pulse_start_and_step();
    for (int c = 1; c < 40; c++) @(negedge clk);
    chk("pre_stop_idx", int'(bus.note_idx), 3);
    chk("pre_stop_music", int'(bus.music), 12);
    do_stop();
    chk("stop_music", int'(bus.music), 0);
    chk("stop_playing", int'(bus.playing), 0);
    chk("stop_done", int'(bus.done), 0);
    chk("stop_idx", int'(bus.note_idx), 0);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk("stop_no_done", int'(bus.done), 0);
    end
    pulse_start_and_step();
    chk("restart_music", int'(bus.music), 8);
    chk("restart_playing", int'(bus.playing), 1);
    do_stop();

    // start and stop together while idle
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("both_music", int'(bus.music), 0);
    chk("both_playing", int'(bus.playing), 0);
    @(negedge clk);
    chk("both_still_idle", int'(bus.playing), 0);

    // reset during the gap after entry 2 (cycles 35..36)
    pulse_start_and_step();
    for (int c = 1; c < 35; c++) @(negedge clk);
    chk("pre_rst_music", int'(bus.music), 0);
    chk("pre_rst_playing", int'(bus.playing), 1);
    chk("pre_rst_idx", int'(bus.note_idx), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_music", int'(bus.music), 0);
    chk("mrst_playing", int'(bus.playing), 0);
    chk("mrst_done", int'(bus.done), 0);
    chk("mrst_idx", int'(bus.note_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) @(negedge clk);
    chk("post_rst_playing", int'(bus.playing), 0);
    chk("post_rst_music", int'(bus.music), 0);
    pulse_start_and_step();
    chk("post_rst_start", int'(bus.music), 8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Plays a fixed tune stored in an internal note ROM. It drives the 5-bit `music` note index consumed by `cal_divnum`, which converts the index to a divider for the tone generator. The block times each note in beats of a parameterised clock count and inserts a short silent gap between notes for articulation. Playback starts and stops on single-cycle control pulses.

## Interface
- `BEAT_CYCLES`, default 12_500_000: clock cycles per beat (0.25 s at 50 MHz); must be ≥ 1.
- `GAP_CYCLES`, default 500_000: silent cycles after every note (10 ms); must be ≥ 1.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse; begins playback from entry 0 when idle.
- `stop`  in  1  single-cycle pulse; aborts playback.
- `music`  out  5  note index to `cal_divnum`, registered; 0 = silence.
- `playing`  out  1  high while a song is in progress (notes or gaps).
- `done`  out  1  single-cycle pulse on natural end of song.
- `note_idx`  out  5  ROM entry currently playing, registered.

## Operation
- ROM: 32 entries × 8 bits, {note[4:0], beats[2:0]}. An entry with beats = 0 is the terminator.
  - Entries 0–13, as note/beats: 8/1, 8/1, 12/1, 12/1, 13/1, 13/1, 12/2, 11/1, 11/1, 10/1, 10/1, 9/1, 9/1, 8/2.
  - Entries 14–31 are terminators (0/0).
- States: IDLE, NOTE, GAP.
- IDLE: `music` = 0, `playing` = 0, `note_idx` = 0.
  - `start` → NOTE with entry 0 loaded.
- NOTE: `music` = ROM note, held for exactly beats × `BEAT_CYCLES` cycles, then → GAP.
- GAP: `music` = 0 for exactly `GAP_CYCLES` cycles. At the end of the gap:
  - If the next entry is a terminator, or the current entry is 31: end of song.
  - Otherwise: increment `note_idx` and → NOTE.
- End of song: `done` = 1 for one cycle, → IDLE.
- `stop` in any state: → IDLE next cycle, `music` = 0, `note_idx` = 0, no `done` pulse.
- `start` while NOTE/GAP: ignored.
- `start` and `stop` in the same cycle: `stop` wins; the block stays or goes IDLE.
- Counting: a 32-bit cycle counter plus a 3-bit beat counter. No multiply is required; the beat counter decrements once per `BEAT_CYCLES` cycles.
- Reset: `music` = 0, `playing` = 0, `done` = 0, `note_idx` = 0, state IDLE. Reset takes effect immediately, mid-note or mid-gap; there is no resume.

## Timing
- Start latency: `start` sampled high at edge k → `music` = ROM[0].note, `playing` = 1 and `note_idx` = 0 from edge k+1.
- Note n occupies beats × `BEAT_CYCLES` consecutive cycles, followed by `GAP_CYCLES` cycles of `music` = 0. There are no extra cycles between phases.
- End of song: if the last gap cycle is cycle t, then in cycle t+1 `playing` = 0 and `done` = 1. `done` returns to 0 in t+2.
- Stop latency: `stop` sampled at edge k → `music` = 0 and `playing` = 0 from edge k+1.
- `music` changes only on clock edges. `cal_divnum` adds one further cycle of latency to the divider.

## Configuration
- `SONG_LOOP_EN` defined:
  - At end of song, `done` still pulses for one cycle.
  - In that same cycle t+1 the block enters NOTE at entry 0: `music` = ROM[0].note, `note_idx` = 0, and `playing` stays 1.
  - Looping continues until `stop` or reset.
- `SONG_LOOP_EN` undefined: the block returns to IDLE after one pass, as described in Operation.

## Test plan
Bench parameters for all scenarios: `BEAT_CYCLES` = 10, `GAP_CYCLES` = 2.
- Reset: assert `rst_n` = 0 → `music` = 0, `playing` = 0, `done` = 0, `note_idx` = 0 with no clock edge required.
- Full song: `start` at edge 0 → `music` = 8 for cycles 1–10, 0 for cycles 11–12, 8 for cycles 13–22. Entry 6 holds `music` = 12 for 20 cycles. The song totals 188 cycles; `done` = 1 and `playing` = 0 at cycle 189.
- Stop mid-note: `stop` during entry 3 → next cycle `music` = 0, `playing` = 0, no `done`. A following `start` replays from entry 0 (`music` = 8).
- Control conflicts:
  - `start` during playback leaves `note_idx` and all timing unchanged.
  - `start` + `stop` in the same cycle while IDLE → remains IDLE with `music` = 0.
- Loop (`SONG_LOOP_EN`): at cycle 189, `done` = 1 and `music` = 8 in the same cycle, `playing` stays 1. The second pass is identical to the first.
- Reset mid-gap: drop `rst_n` during the gap after entry 2 → all outputs 0 immediately. After release, the block stays IDLE until `start`.
